// File: rtl/spi_packet_decoder.sv
// Frames 3-byte SPI packets (start, address, data) into register-file writes,
// flagging bad start bytes, out-of-range addresses, inter-byte timeouts and aborts.
module spi_packet_decoder #(
    parameter int unsigned FILE_SIZE_BYTES = 26,
    parameter logic [7:0]  START_BYTE      = 8'hF0,
    parameter int unsigned TIMEOUT_CLKS    = 10000
) (
    input  logic        i_clk_10,
    input  logic        i_rst,
    input  logic        i_ssel,
    input  logic        i_byte_dv,
    input  logic [7:0]  i_byte,
    output logic        o_write,
    output logic [7:0]  o_wr_addr,
    output logic [7:0]  o_wr_byte,
    output logic        o_busy,
    output logic        o_err,
    output logic [1:0]  o_err_code,
    output logic [15:0] o_wr_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ERR_START   = 2'd0,
        ERR_RANGE   = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_ABORT   = 2'd3
    } err_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CLKS - 1);

    state_t      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_byte_q, wr_byte_d;
    logic        write_q, write_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [15:0] wr_count_q, wr_count_d;
    logic [15:0] tmo_q, tmo_d;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wr_addr_d  = wr_addr_q;
        wr_byte_d  = wr_byte_q;
        write_d    = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        wr_count_d = wr_count_q;
        tmo_d      = tmo_q;

        case (state_q)
            IDLE: begin
                if (i_byte_dv) begin
                    if (i_byte == START_BYTE) begin
                        state_d = ADDR;
                        tmo_d   = '0;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_START;
                    end
                end
            end
            ADDR, DATA: begin
                // Abort beats a same-cycle byte, and a byte beats an expiring timer.
                if (i_ssel) begin
                    state_d    = IDLE;
                    tmo_d      = '0;
                    err_d      = 1'b1;
                    err_code_d = ERR_ABORT;
                end else if (i_byte_dv) begin
                    tmo_d = '0;
                    if (state_q == ADDR) begin
                        addr_d  = i_byte;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                        if ({24'd0, addr_q} < FILE_SIZE_BYTES) begin
                            wr_addr_d  = addr_q;
                            wr_byte_d  = i_byte;
                            write_d    = 1'b1;
                            wr_count_d = wr_count_q + 16'd1;
                        end else begin
                            err_d      = 1'b1;
                            err_code_d = ERR_RANGE;
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d    = IDLE;
                    tmo_d      = '0;
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tmo_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk_10) begin
        if (!i_rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wr_addr_q  <= '0;
            wr_byte_q  <= '0;
            write_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            wr_count_q <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wr_addr_q  <= wr_addr_d;
            wr_byte_q  <= wr_byte_d;
            write_q    <= write_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            wr_count_q <= wr_count_d;
            tmo_q      <= tmo_d;
        end
    end

    assign o_write    = write_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_wr_byte  = wr_byte_q;
    assign o_busy     = busy_q;
    assign o_err      = err_q;
    assign o_err_code = err_code_q;
    assign o_wr_count = wr_count_q;

endmodule

// File: tb/tb_spi_packet_decoder.sv
// Directed bench for spi_packet_decoder: expected writes/errors are queued as
// bytes are driven and popped when the decoder strobes o_write or o_err.
module tb_spi_packet_decoder;

    localparam int unsigned TMO = 10000;

    logic        clk;
    logic        i_rst;
    logic        i_ssel;
    logic        i_byte_dv;
    logic [7:0]  i_byte;
    logic        o_write;
    logic [7:0]  o_wr_addr;
    logic [7:0]  o_wr_byte;
    logic        o_busy;
    logic        o_err;
    logic [1:0]  o_err_code;
    logic [15:0] o_wr_count;

    typedef struct packed {
        logic [7:0]  addr;
        logic [7:0]  data;
        logic [15:0] count;
    } wr_t;

    wr_t        wq[$];
    logic [1:0] eq[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [15:0] wc = 16'd0;

    spi_packet_decoder #(
        .FILE_SIZE_BYTES(26),
        .START_BYTE(8'hF0),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .i_clk_10(clk),
        .i_rst(i_rst),
        .i_ssel(i_ssel),
        .i_byte_dv(i_byte_dv),
        .i_byte(i_byte),
        .o_write(o_write),
        .o_wr_addr(o_wr_addr),
        .o_wr_byte(o_wr_byte),
        .o_busy(o_busy),
        .o_err(o_err),
        .o_err_code(o_err_code),
        .o_wr_count(o_wr_count)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        wr_t w;
        wc = wc + 16'd1;
        w.addr  = a;
        w.data  = d;
        w.count = wc;
        wq.push_back(w);
    endtask

    // One clock: outputs are observed on the falling edge after the rising edge.
    task automatic tick();
        wr_t w;
        logic [1:0] c;
        @(posedge clk);
        @(negedge clk);
        if (o_write && o_err) chk("write_err_overlap", 32'(o_err), 32'd0);
        if (o_write) begin
            if (wq.size() == 0) begin
                chk("unexpected_write", 32'(o_write), 32'd0);
            end else begin
                w = wq.pop_front();
                chk("wr_addr", 32'(o_wr_addr), 32'(w.addr));
                chk("wr_byte", 32'(o_wr_byte), 32'(w.data));
                chk("wr_count", 32'(o_wr_count), 32'(w.count));
            end
        end
        if (o_err) begin
            if (eq.size() == 0) begin
                chk("unexpected_err", 32'(o_err), 32'd0);
            end else begin
                c = eq.pop_front();
                chk("err_code", 32'(o_err_code), 32'(c));
            end
        end
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [7:0] b);
        i_byte    = b;
        i_byte_dv = 1'b1;
        tick();
        i_byte_dv = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_write"}, 32'(o_write), 32'd0);
        chk({tag, "_addr"}, 32'(o_wr_addr), 32'd0);
        chk({tag, "_byte"}, 32'(o_wr_byte), 32'd0);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_err"}, 32'(o_err), 32'd0);
        chk({tag, "_code"}, 32'(o_err_code), 32'd0);
        chk({tag, "_count"}, 32'(o_wr_count), 32'd0);
    endtask

    initial begin
        i_rst     = 1'b0;
        i_ssel    = 1'b0;
        i_byte_dv = 1'b0;
        i_byte    = 8'h00;
        @(negedge clk);
        ticks(2);
        chk_reset_vals("reset");
        i_rst = 1'b1;
        ticks(2);

        // Valid write with 20-clock gaps
        send(8'hF0);
        chk("busy_after_start", 32'(o_busy), 32'd1);
        ticks(19);
        send(8'h05);
        ticks(19);
        push_wr(8'h05, 8'h3C);
        chk("write_pulse", 32'(o_write), 32'd0);
        send(8'h3C);
        chk("write_high", 32'(o_write), 32'd1);
        chk("busy_after_data", 32'(o_busy), 32'd0);
        tick();
        chk("write_one_cycle", 32'(o_write), 32'd0);
        chk("addr_held", 32'(o_wr_addr), 32'h05);

        // Bad start byte, then a good packet
        eq.push_back(2'd0);
        send(8'h7A);
        chk("bad_start_idle", 32'(o_busy), 32'd0);
        send(8'hF0);
        send(8'h19);
        push_wr(8'h19, 8'hFF);
        send(8'hFF);
        tick();

        // Address out of range (26 is first invalid)
        send(8'hF0);
        send(8'h1A);
        eq.push_back(2'd1);
        send(8'h55);
        chk("range_err", 32'(o_err), 32'd1);
        tick();
        chk("range_addr_kept", 32'(o_wr_addr), 32'h19);
        chk("range_byte_kept", 32'(o_wr_byte), 32'hFF);
        chk("range_count_kept", 32'(o_wr_count), 32'(wc));

        // Timeout: error exactly TMO clocks after the start byte
        send(8'hF0);
        ticks(TMO - 1);
        chk("tmo_busy_before", 32'(o_busy), 32'd1);
        eq.push_back(2'd2);
        tick();
        chk("tmo_err", 32'(o_err), 32'd1);
        chk("tmo_busy_after", 32'(o_busy), 32'd0);
        tick();

        // Byte arriving in the expiry cycle is accepted
        send(8'hF0);
        ticks(TMO - 1);
        send(8'h07);
        chk("tmo_boundary_busy", 32'(o_busy), 32'd1);
        push_wr(8'h07, 8'h11);
        send(8'h11);
        tick();

        // Abort while waiting for data
        send(8'hF0);
        send(8'h02);
        i_ssel = 1'b1;
        eq.push_back(2'd3);
        tick();
        i_ssel = 1'b0;
        chk("abort_busy", 32'(o_busy), 32'd0);
        tick();

        // Abort coincident with the data byte
        send(8'hF0);
        send(8'h02);
        i_ssel = 1'b1;
        eq.push_back(2'd3);
        send(8'h44);
        i_ssel = 1'b0;
        chk("abort_same_cycle_err", 32'(o_err), 32'd1);
        tick();
        chk("abort_count_kept", 32'(o_wr_count), 32'(wc));

        // Back-to-back: next start byte driven while o_write is high
        send(8'hF0);
        send(8'h0A);
        push_wr(8'h0A, 8'hB1);
        send(8'hB1);
        chk("b2b_first_write", 32'(o_write), 32'd1);
        send(8'hF0);
        send(8'h0B);
        push_wr(8'h0B, 8'hB2);
        send(8'hB2);
        tick();

        // Counter wrap from 65535
        force dut.wr_count_q = 16'hFFFF;
        tick();
        release dut.wr_count_q;
        tick();
        wc = 16'hFFFF;
        chk("preload_count", 32'(o_wr_count), 32'hFFFF);
        send(8'hF0);
        send(8'h03);
        push_wr(8'h03, 8'h77);
        send(8'h77);
        chk("wrap_count", 32'(o_wr_count), 32'd0);
        tick();

        // Reset mid-packet drops it silently
        send(8'hF0);
        send(8'h03);
        i_rst = 1'b0;
        tick();
        chk_reset_vals("midreset");
        i_rst = 1'b1;
        wc = 16'd0;
        tick();
        send(8'hF0);
        send(8'h03);
        push_wr(8'h03, 8'hAA);
        send(8'hAA);
        ticks(3);

        chk("pending_writes", 32'(wq.size()), 32'd0);
        chk("pending_errors", 32'(eq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
